// File: rtl/mc_controller.sv
// Multicycle control unit for the ARM datapath.
// Moore FSM sequencing fetch/decode/execute/memory/writeback, holding the
// NZCV flags and gating all architectural writes on the condition field.
module mc_controller (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] Instr,
   input  logic [3:0]  ALUFlags,
   output logic        PCWrite,
   output logic        IRWrite,
   output logic        RegWrite,
   output logic        MemWrite,
   output logic        AdrSrc,
   output logic [1:0]  RegSrc,
   output logic [1:0]  ALUSrcA,
   output logic [1:0]  ALUSrcB,
   output logic [1:0]  ResultSrc,
   output logic [1:0]  ImmSrc,
   output logic [1:0]  ALUControl
);

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECR    = 4'd6,
      S_EXECI    = 4'd7,
      S_ALUWB    = 4'd8,
      S_BRANCH   = 4'd9
   } state_t;

   // Condition check against the {N,Z,C,V} flags; 1111 never executes.
   function automatic logic cond_ex(input logic [3:0] cond, input logic [3:0] flags);
      logic n, z, c, v;
      {n, z, c, v} = flags;
      case (cond)
         4'b0000: cond_ex = z;
         4'b0001: cond_ex = ~z;
         4'b0010: cond_ex = c;
         4'b0011: cond_ex = ~c;
         4'b0100: cond_ex = n;
         4'b0101: cond_ex = ~n;
         4'b0110: cond_ex = v;
         4'b0111: cond_ex = ~v;
         4'b1000: cond_ex = c & ~z;
         4'b1001: cond_ex = ~c | z;
         4'b1010: cond_ex = (n == v);
         4'b1011: cond_ex = (n != v);
         4'b1100: cond_ex = ~z & (n == v);
         4'b1101: cond_ex = z | (n != v);
         4'b1110: cond_ex = 1'b1;
         default: cond_ex = 1'b0;
      endcase
   endfunction

   state_t      state_r;
   state_t      state_next_s;
   logic [3:0]  flags_r;
   logic        cond_ok_r;

   logic [3:0]  cond_s;
   logic [1:0]  op_s;
   logic [5:0]  funct_s;
   logic [1:0]  alu_dec_s;
   logic        cmd_valid_s;
   logic        alu_arith_s;
   logic        flag_we_s;

   logic        pc_write_s;
   logic        ir_write_s;
   logic        reg_write_s;
   logic        mem_write_s;
   logic        adr_src_s;
   logic [1:0]  alu_src_a_s;
   logic [1:0]  alu_src_b_s;
   logic [1:0]  result_src_s;
   logic [1:0]  alu_control_s;

   assign cond_s  = Instr[31:28];
   assign op_s    = Instr[27:26];
   assign funct_s = Instr[25:20];

   // Next-state selection; unknown encodings fall back to FETCH.
   always_comb begin
      state_next_s = S_FETCH;
      case (state_r)
         S_FETCH:  state_next_s = S_DECODE;
         S_DECODE: begin
            case (op_s)
               2'b01:   state_next_s = S_MEMADR;
               2'b00:   state_next_s = funct_s[5] ? S_EXECI : S_EXECR;
               2'b10:   state_next_s = S_BRANCH;
               default: state_next_s = S_FETCH;
            endcase
         end
         S_MEMADR:   state_next_s = funct_s[0] ? S_MEMREAD : S_MEMWRITE;
         S_MEMREAD:  state_next_s = S_MEMWB;
         S_MEMWB:    state_next_s = S_FETCH;
         S_MEMWRITE: state_next_s = S_FETCH;
         S_EXECR:    state_next_s = S_ALUWB;
         S_EXECI:    state_next_s = S_ALUWB;
         S_ALUWB:    state_next_s = S_FETCH;
         S_BRANCH:   state_next_s = S_FETCH;
         default:    state_next_s = S_FETCH;
      endcase
   end

   // State register; reset restarts at FETCH and abandons the current instruction.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= S_FETCH;
      end else begin
         state_r <= state_next_s;
      end
   end

   // ALU command decode; unsupported commands mark the instruction as non-writing.
   always_comb begin
      alu_dec_s   = 2'b00;
      cmd_valid_s = 1'b0;
      alu_arith_s = 1'b0;
      case (funct_s[4:1])
         4'b0100: begin alu_dec_s = 2'b00; cmd_valid_s = 1'b1; alu_arith_s = 1'b1; end
         4'b0010: begin alu_dec_s = 2'b01; cmd_valid_s = 1'b1; alu_arith_s = 1'b1; end
         4'b0000: begin alu_dec_s = 2'b10; cmd_valid_s = 1'b1; alu_arith_s = 1'b0; end
         4'b1100: begin alu_dec_s = 2'b11; cmd_valid_s = 1'b1; alu_arith_s = 1'b0; end
         default: begin alu_dec_s = 2'b00; cmd_valid_s = 1'b0; alu_arith_s = 1'b0; end
      endcase
   end

   assign flag_we_s = ((state_r == S_EXECR) || (state_r == S_EXECI)) &&
                      funct_s[0] && cond_ok_r && cmd_valid_s;

   // Condition latched once in DECODE so a flag update cannot affect its own writeback.
   always_ff @(posedge clk) begin
      if (reset) begin
         cond_ok_r <= 1'b0;
      end else if (state_r == S_DECODE) begin
         cond_ok_r <= cond_ex(cond_s, flags_r);
      end else begin
         cond_ok_r <= cond_ok_r;
      end
   end

   // NZCV register; C and V only follow the ALU for arithmetic operations.
   always_ff @(posedge clk) begin
      if (reset) begin
         flags_r <= 4'b0000;
      end else if (flag_we_s) begin
         flags_r[3:2] <= ALUFlags[3:2];
         flags_r[1:0] <= alu_arith_s ? ALUFlags[1:0] : flags_r[1:0];
      end else begin
         flags_r <= flags_r;
      end
   end

   // Per-state Moore outputs before the reset override.
   always_comb begin
      pc_write_s    = 1'b0;
      ir_write_s    = 1'b0;
      reg_write_s   = 1'b0;
      mem_write_s   = 1'b0;
      adr_src_s     = 1'b0;
      alu_src_a_s   = 2'b00;
      alu_src_b_s   = 2'b00;
      result_src_s  = 2'b00;
      alu_control_s = 2'b00;
      case (state_r)
         S_FETCH: begin
            ir_write_s   = 1'b1;
            pc_write_s   = 1'b1;
            alu_src_a_s  = 2'b01;
            alu_src_b_s  = 2'b10;
            result_src_s = 2'b10;
         end
         S_DECODE: begin
            alu_src_a_s  = 2'b01;
            alu_src_b_s  = 2'b10;
            result_src_s = 2'b10;
         end
         S_MEMADR:   alu_src_b_s = 2'b01;
         S_MEMREAD:  adr_src_s   = 1'b1;
         S_MEMWB: begin
            result_src_s = 2'b01;
            reg_write_s  = cond_ok_r;
         end
         S_MEMWRITE: begin
            adr_src_s   = 1'b1;
            mem_write_s = cond_ok_r;
         end
         S_EXECR:    alu_control_s = alu_dec_s;
         S_EXECI: begin
            alu_src_b_s   = 2'b01;
            alu_control_s = alu_dec_s;
         end
         S_ALUWB:    reg_write_s = cond_ok_r & cmd_valid_s;
         S_BRANCH: begin
            alu_src_b_s  = 2'b01;
            result_src_s = 2'b10;
            pc_write_s   = cond_ok_r;
         end
         default: begin
            pc_write_s = 1'b0;
         end
      endcase
   end

   // During reset the enables are held off and the muxes show their FETCH settings.
   assign PCWrite    = pc_write_s  & ~reset;
   assign IRWrite    = ir_write_s  & ~reset;
   assign RegWrite   = reg_write_s & ~reset;
   assign MemWrite   = mem_write_s & ~reset;
   assign AdrSrc     = reset ? 1'b0  : adr_src_s;
   assign ALUSrcA    = reset ? 2'b01 : alu_src_a_s;
   assign ALUSrcB    = reset ? 2'b10 : alu_src_b_s;
   assign ResultSrc  = reset ? 2'b10 : result_src_s;
   assign ALUControl = reset ? 2'b00 : alu_control_s;

   // Static decode, valid in every state.
   assign ImmSrc    = op_s;
   assign RegSrc[0] = (op_s == 2'b10);
   assign RegSrc[1] = (op_s == 2'b01) && (funct_s[0] == 1'b0);

endmodule

// File: tb/tb_mc_controller.sv
// Directed self-checking bench for mc_controller.
module tb_mc_controller;

   logic        clk;
   logic        reset;
   logic [31:0] Instr;
   logic [3:0]  ALUFlags;
   logic        PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc;
   logic [1:0]  RegSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl;
   logic [16:0] outv;

   int total_cnt = 0;
   int bad_cnt   = 0;

   mc_controller dut (
      .clk(clk), .reset(reset), .Instr(Instr), .ALUFlags(ALUFlags),
      .PCWrite(PCWrite), .IRWrite(IRWrite), .RegWrite(RegWrite),
      .MemWrite(MemWrite), .AdrSrc(AdrSrc), .RegSrc(RegSrc),
      .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc),
      .ImmSrc(ImmSrc), .ALUControl(ALUControl)
   );

   assign outv = {PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, RegSrc,
                  ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl};

   // Free-running clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Pack expected output fields in the same order as outv.
   function automatic logic [16:0] pk(input logic pcw, input logic irw, input logic rw,
                                      input logic mw, input logic adr, input logic [1:0] rsrc,
                                      input logic [1:0] asa, input logic [1:0] asb,
                                      input logic [1:0] res, input logic [1:0] imm,
                                      input logic [1:0] alu);
      return {pcw, irw, rw, mw, adr, rsrc, asa, asb, res, imm, alu};
   endfunction

   task automatic chk(input string tag, input logic [16:0] got, input logic [16:0] exp);
      total_cnt++;
      if (got !== exp) begin
         bad_cnt++;
         $display("FAIL %s: got=%b expected=%b", tag, got, exp);
      end
   endtask

   // Check the current cycle's outputs, then advance one clock.
   task automatic cyc(input string tag, input logic [16:0] exp);
      #1;
      chk(tag, outv, exp);
      @(posedge clk);
      #1;
   endtask

   // Data-processing instruction (Op=00): FETCH, DECODE, EXEC, ALUWB.
   task automatic do_dp(input string tag, input logic [31:0] ins, input logic [1:0] alu,
                        input logic [3:0] fl, input logic rw);
      logic [1:0] asb;
      asb = ins[25] ? 2'b01 : 2'b00;
      Instr = ins;
      cyc({tag, "_f"}, pk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b10, 2'b10, 2'b00, 2'b00));
      cyc({tag, "_d"}, pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b10, 2'b10, 2'b00, 2'b00));
      ALUFlags = fl;
      cyc({tag, "_x"}, pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, asb, 2'b00, 2'b00, alu));
      ALUFlags = 4'b0000;
      cyc({tag, "_wb"}, pk(1'b0, 1'b0, rw, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00));
   endtask

   // Branch instruction (Op=10): FETCH, DECODE, BRANCH.
   task automatic do_br(input string tag, input logic [31:0] ins, input logic taken);
      Instr = ins;
      cyc({tag, "_f"}, pk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 2'b01, 2'b10, 2'b10, 2'b10, 2'b00));
      cyc({tag, "_d"}, pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b01, 2'b10, 2'b10, 2'b10, 2'b00));
      cyc({tag, "_b"}, pk(taken, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 2'b01, 2'b10, 2'b10, 2'b00));
   endtask

   // Store (Op=01, L=0) up to and including MEMADR.
   task automatic str_front(input string tag, input logic [31:0] ins);
      Instr = ins;
      cyc({tag, "_f"}, pk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b10, 2'b01, 2'b10, 2'b10, 2'b01, 2'b00));
      cyc({tag, "_d"}, pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b01, 2'b10, 2'b10, 2'b01, 2'b00));
      cyc({tag, "_a"}, pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 2'b01, 2'b00, 2'b01, 2'b00));
   endtask

   initial begin
      reset    = 1'b1;
      Instr    = 32'h0000_0000;
      ALUFlags = 4'b0000;
      @(posedge clk);
      @(posedge clk);
      #1;
      chk("rst_hold", outv, pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b10, 2'b10, 2'b00, 2'b00));
      reset = 1'b0;

      // Unsupported command (CMP): no register write, no flag write.
      do_dp("cmp", 32'hE351_0000, 2'b00, 4'b0100, 1'b0);
      do_br("beq0", 32'h0A00_0002, 1'b0);                 // Z still 0

      // ADDS imm sets Z.
      do_dp("adds", 32'hE291_0005, 2'b00, 4'b0100, 1'b1);
      do_br("beq1", 32'h0A00_0002, 1'b1);
      do_br("bne1", 32'h1A00_0002, 1'b0);

      // SUBS reg: Z=0, C=1.
      do_dp("subs1", 32'hE051_0002, 2'b01, 4'b0010, 1'b1);
      do_br("bne2", 32'h1A00_0002, 1'b1);
      // ANDS imm: Z=1, C held at 1 despite ALUFlags C=0.
      do_dp("ands", 32'hE211_0005, 2'b10, 4'b0100, 1'b1);
      do_br("bcs1", 32'h2A00_0002, 1'b1);
      do_br("bhi", 32'h8A00_0002, 1'b0);                  // C & !Z = 0
      // ORRS imm: N=1, Z=0.
      do_dp("orrs", 32'hE391_0005, 2'b11, 4'b1000, 1'b1);
      do_br("bmi", 32'h4A00_0002, 1'b1);
      // SUBS: Z=1, C=0.
      do_dp("subs2", 32'hE051_0002, 2'b01, 4'b0100, 1'b1);
      do_br("bcs2", 32'h2A00_0002, 1'b0);

      // LDR: five-cycle sequence.
      Instr = 32'hE591_2004;
      cyc("ldr_f",  pk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b10, 2'b10, 2'b01, 2'b00));
      cyc("ldr_d",  pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b10, 2'b10, 2'b01, 2'b00));
      cyc("ldr_a",  pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b01, 2'b00, 2'b01, 2'b00));
      cyc("ldr_r",  pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00));
      cyc("ldr_wb", pk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b01, 2'b01, 2'b00));

      // STR: MemWrite in MEMWRITE.
      str_front("str", 32'hE581_2004);
      cyc("str_w", pk(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'b10, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00));

      // ADDNE with Z=1 and S=1: no write, flags unchanged.
      do_dp("addne", 32'h1291_0005, 2'b00, 4'b0000, 1'b0);
      do_br("beq2", 32'h0A00_0002, 1'b1);

      // Cond=1111 store: no memory write.
      str_front("strnv", 32'hF581_2004);
      cyc("strnv_w", pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00));

      // Op=11 no-op: FETCH, DECODE, back to FETCH.
      Instr = 32'hEC00_0000;
      cyc("nop_f", pk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b10, 2'b10, 2'b11, 2'b00));
      cyc("nop_d", pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b10, 2'b10, 2'b11, 2'b00));

      // Reset asserted in MEMWRITE: no write, FETCH next, flags cleared.
      str_front("strrst", 32'hE581_2004);
      reset = 1'b1;
      #1;
      chk("rst_mw", outv, pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b01, 2'b10, 2'b10, 2'b01, 2'b00));
      @(posedge clk);
      #1;
      reset = 1'b0;
      do_br("beq_post", 32'h0A00_0002, 1'b0);             // Z cleared by reset

      $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
      $finish;
   end

endmodule
